register_restore_engine: RTL and testbench

//  Other half of the register checkpoint path. When a branch misprediction is resolved, writes the saved

---
 rtl/register_restore_engine_pkg.sv | 19 +
 rtl/register_restore_engine.sv | 138 +++++++++++++
 tb/tb_register_restore_engine.sv | 265 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/register_restore_engine_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | register_restore_engine_pkg : shared widths and FSM states for the restore  |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
package register_restore_engine_pkg;

  localparam int DATA_WIDTH       = 32;
  localparam int NUM_REGS_DEFAULT = 32;
  localparam int REG_AW           = $clog2(NUM_REGS_DEFAULT);

  typedef enum logic [1:0] {
    RR_IDLE    = 2'd0,
    RR_RESTORE = 2'd1,
    RR_DONE    = 2'd2
  } restore_state_t;

endpackage
`default_nettype wire

// File: rtl/register_restore_engine.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | register_restore_engine : replays a checkpointed register snapshot into the |
// | reg file write ports after a misprediction.  Rev 1.0                        |
// +-----------------------------------------------------------------------------+
module register_restore_engine
  import register_restore_engine_pkg::*;
#(
  parameter int NUM_REGS  = 32,
  parameter int WR_PORTS  = 2,
  parameter int SKIP_ZERO = 1
) (
  input  logic                                  clk,
  input  logic                                  rst_n,
  input  logic                                  snapshot_valid,
  input  logic [NUM_REGS*DATA_WIDTH-1:0]        regs_snapshot,
  input  logic                                  recover_req,
  input  logic                                  recover_ack,
  output logic [WR_PORTS-1:0]                   wr_en,
  output logic [WR_PORTS*$clog2(NUM_REGS)-1:0]  wr_addr,
  output logic [WR_PORTS*DATA_WIDTH-1:0]        wr_data,
  output logic                                  busy,
  output logic                                  recover_done,
  output logic                                  snapshot_ack,
  output logic                                  recover_err
);

  localparam int ADDR_W = $clog2(NUM_REGS);
  localparam int IDX_W  = ADDR_W + 1;
  localparam int FIRST  = (SKIP_ZERO != 0) ? 1 : 0;

  restore_state_t        state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [IDX_W:0]        idx_next_w;
  logic                  snapshot_ack_q, snapshot_ack_d;
  logic                  recover_err_q, recover_err_d;
  logic                  load_w;
  logic [DATA_WIDTH-1:0] buf_q [FIRST:NUM_REGS-1];
  logic [DATA_WIDTH-1:0] buf_d [FIRST:NUM_REGS-1];
  logic                  unused_w;

  // Register 0 is never replayed when SKIP_ZERO is set, so its snapshot bits go nowhere.
  assign unused_w   = ^regs_snapshot[DATA_WIDTH-1:0];
  assign idx_next_w = {1'b0, idx_q} + (IDX_W+1)'(WR_PORTS);

  always_comb begin
    state_d        = state_q;
    idx_d          = idx_q;
    load_w         = 1'b0;
    snapshot_ack_d = 1'b0;
    recover_err_d  = 1'b0;
    case (state_q)
      RR_IDLE: begin
        if (recover_req) begin
          if (snapshot_valid) begin
            load_w  = 1'b1;
            idx_d   = IDX_W'(FIRST);
            state_d = RR_RESTORE;
          end else begin
            recover_err_d = 1'b1;
          end
        end
      end
      RR_RESTORE: begin
        idx_d = idx_next_w[IDX_W-1:0];
        if (idx_next_w >= (IDX_W+1)'(NUM_REGS)) begin
          state_d        = RR_DONE;
          snapshot_ack_d = 1'b1;
        end
      end
      RR_DONE: begin
        if (recover_ack) begin
          state_d = RR_IDLE;
        end
      end
      default: state_d = RR_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= RR_IDLE;
      idx_q          <= '0;
      snapshot_ack_q <= 1'b0;
      recover_err_q  <= 1'b0;
    end else begin
      state_q        <= state_d;
      idx_q          <= idx_d;
      snapshot_ack_q <= snapshot_ack_d;
      recover_err_q  <= recover_err_d;
    end
  end

  // Private copy taken at acceptance; the holder may change its snapshot mid-restore.
  always_comb begin
    buf_d = buf_q;
    if (load_w) begin
      for (int r = FIRST; r < NUM_REGS; r++) begin
        buf_d[r] = regs_snapshot[r*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  for (genvar p = 0; p < WR_PORTS; p++) begin : g_port
    logic [IDX_W:0]        a_w;
    logic                  en_w;
    logic [DATA_WIDTH-1:0] data_w;

    assign a_w  = {1'b0, idx_q} + (IDX_W+1)'(p);
    assign en_w = (state_q == RR_RESTORE) && (a_w < (IDX_W+1)'(NUM_REGS));

    always_comb begin
      data_w = '0;
      if (en_w) begin
        for (int r = FIRST; r < NUM_REGS; r++) begin
          if (a_w == (IDX_W+1)'(r)) begin
            data_w = buf_q[r];
          end
        end
      end
    end

    assign wr_en[p]                             = en_w;
    assign wr_addr[p*ADDR_W +: ADDR_W]          = (state_q == RR_RESTORE) ? a_w[ADDR_W-1:0] : '0;
    assign wr_data[p*DATA_WIDTH +: DATA_WIDTH]  = data_w;
  end

  assign busy         = (state_q != RR_IDLE);
  assign recover_done = (state_q == RR_DONE);
  assign snapshot_ack = snapshot_ack_q;
  assign recover_err  = recover_err_q;

endmodule
`default_nettype wire

// File: tb/tb_register_restore_engine.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_register_restore_engine : scoreboard bench for two engine configurations |
// | Rev 1.0                                                                     |
// +-----------------------------------------------------------------------------+
module tb_register_restore_engine;
  import register_restore_engine_pkg::*;

  localparam int N  = 32;
  localparam int DW = DATA_WIDTH;
  localparam int AW = 5;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // Configuration A: two ports, r0 skipped
  logic            a_valid, a_req, a_ack;
  logic [N*DW-1:0] a_snap;
  logic [1:0]      a_wr_en;
  logic [2*AW-1:0] a_wr_addr;
  logic [2*DW-1:0] a_wr_data;
  logic            a_busy, a_done, a_sack, a_err;

  // Configuration B: one port, r0 included
  logic            b_valid, b_req, b_ack;
  logic [N*DW-1:0] b_snap;
  logic [0:0]      b_wr_en;
  logic [AW-1:0]   b_wr_addr;
  logic [DW-1:0]   b_wr_data;
  logic            b_busy, b_done, b_sack, b_err;

  register_restore_engine #(.NUM_REGS(N), .WR_PORTS(2), .SKIP_ZERO(1)) u_a (
    .clk(clk), .rst_n(rst_n), .snapshot_valid(a_valid), .regs_snapshot(a_snap),
    .recover_req(a_req), .recover_ack(a_ack), .wr_en(a_wr_en), .wr_addr(a_wr_addr),
    .wr_data(a_wr_data), .busy(a_busy), .recover_done(a_done), .snapshot_ack(a_sack),
    .recover_err(a_err)
  );

  register_restore_engine #(.NUM_REGS(N), .WR_PORTS(1), .SKIP_ZERO(0)) u_b (
    .clk(clk), .rst_n(rst_n), .snapshot_valid(b_valid), .regs_snapshot(b_snap),
    .recover_req(b_req), .recover_ack(b_ack), .wr_en(b_wr_en), .wr_addr(b_wr_addr),
    .wr_data(b_wr_data), .busy(b_busy), .recover_done(b_done), .snapshot_ack(b_sack),
    .recover_err(b_err)
  );

  int checks   = 0;
  int failures = 0;
  int a_sack_cnt = 0;
  int b_sack_cnt = 0;

  logic [AW-1:0] a_exp_addr[$];
  logic [DW-1:0] a_exp_data[$];
  logic [AW-1:0] b_exp_addr[$];
  logic [DW-1:0] b_exp_data[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitors: every asserted write must be the next register the model expects.
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_sack) a_sack_cnt++;
      if (a_wr_en == 2'b11)
        chk("a_same_cycle_distinct_addr", 64'(a_wr_addr[AW-1:0] == a_wr_addr[2*AW-1:AW]), 0);
      for (int p = 0; p < 2; p++) begin
        if (a_wr_en[p]) begin
          if (a_exp_addr.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL a_unexpected_write actual_addr=%0d required=none", a_wr_addr[p*AW +: AW]);
          end else begin
            chk("a_wr_addr", a_wr_addr[p*AW +: AW], a_exp_addr.pop_front());
            chk("a_wr_data", a_wr_data[p*DW +: DW], a_exp_data.pop_front());
          end
        end else begin
          chk("a_wr_data_idle_zero", a_wr_data[p*DW +: DW], 0);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (b_sack) b_sack_cnt++;
      if (b_wr_en[0]) begin
        if (b_exp_addr.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL b_unexpected_write actual_addr=%0d required=none", b_wr_addr);
        end else begin
          chk("b_wr_addr", b_wr_addr, b_exp_addr.pop_front());
          chk("b_wr_data", b_wr_data, b_exp_data.pop_front());
        end
      end
    end
  end

  // Reference model: a full snapshot replays registers first..N-1 in ascending order.
  task automatic load_a(input bit fixed);
    for (int r = 0; r < N; r++)
      a_snap[r*DW +: DW] = fixed ? (32'hA000_0000 + 32'(r)) : 32'($urandom);
    for (int r = 1; r < N; r++) begin
      a_exp_addr.push_back(AW'(r));
      a_exp_data.push_back(a_snap[r*DW +: DW]);
    end
  endtask

  task automatic run_a(input int ack_delay, input int scramble_at, input bit fixed);
    int n;
    int s0;
    logic [1:0] last;
    load_a(fixed);
    s0 = a_sack_cnt;
    a_valid = 1'b1;
    a_req   = 1'b1;
    tick();
    a_req = 1'b0;
    chk("a_busy_after_req", a_busy, 1);
    chk("a_first_wr_en", a_wr_en, 2'b11);
    n    = 0;
    last = '0;
    while (!a_done && n < 40) begin
      if (n == scramble_at) begin
        for (int r = 0; r < N; r++) a_snap[r*DW +: DW] = 32'($urandom);
        a_valid = 1'b0;
        a_req   = 1'b1;
      end
      last = a_wr_en;
      tick();
      n++;
    end
    chk("a_restore_cycles", n, (N - 1 + 2 - 1) / 2);
    chk("a_last_wr_en", last, 2'b01);
    chk("a_sack_first_done", a_sack, 1);
    chk("a_all_regs_written", a_exp_addr.size(), 0);
    a_valid = 1'b1;
    a_req   = 1'b1;
    for (int i = 0; i < ack_delay; i++) begin
      tick();
      chk("a_done_held", {a_busy, a_done}, 2'b11);
      chk("a_sack_low_after_first", a_sack, 0);
    end
    a_ack = 1'b1;
    tick();
    chk("a_idle_after_ack", {a_busy, a_done}, 2'b00);
    a_ack = 1'b0;
    a_req = 1'b0;
    tick();
    chk("a_req_with_ack_dropped", a_busy, 0);
    chk("a_sack_once", a_sack_cnt - s0, 1);
  endtask

  task automatic run_b();
    int n;
    for (int r = 0; r < N; r++) begin
      b_snap[r*DW +: DW] = 32'($urandom);
      b_exp_addr.push_back(AW'(r));
      b_exp_data.push_back(b_snap[r*DW +: DW]);
    end
    b_valid = 1'b1;
    b_req   = 1'b1;
    tick();
    b_req   = 1'b0;
    b_valid = 1'b0;
    chk("b_first_wr_en", b_wr_en, 1);
    n = 0;
    while (!b_done && n < 80) begin
      tick();
      n++;
    end
    chk("b_restore_cycles", n, N);
    chk("b_all_regs_written", b_exp_addr.size(), 0);
    chk("b_sack_first_done", b_sack, 1);
    b_ack = 1'b1;
    tick();
    b_ack = 1'b0;
    chk("b_idle_after_ack", {b_busy, b_done}, 2'b00);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    {a_valid, a_req, a_ack} = '0;
    {b_valid, b_req, b_ack} = '0;
    a_snap = '0;
    b_snap = '0;
    tick();
    tick();
    chk("reset_a_outputs", {a_wr_en, a_wr_addr, a_busy, a_done, a_sack, a_err}, 0);
    chk("reset_a_wr_data", a_wr_data, 0);
    chk("reset_b_outputs", {b_wr_en, b_wr_addr, b_busy, b_done, b_sack, b_err}, 0);
    rst_n = 1'b1;
    tick();

    // Basic restore with recognisable data and a long ack wait
    run_a(10, -1, 1'b1);

    // Request without a snapshot
    a_valid = 1'b0;
    a_req   = 1'b1;
    tick();
    a_req = 1'b0;
    chk("err_pulse", a_err, 1);
    chk("err_not_busy", a_busy, 0);
    chk("err_no_write", a_wr_en, 0);
    tick();
    chk("err_pulse_one_cycle", a_err, 0);
    chk("err_still_idle", a_busy, 0);

    // Snapshot scrambled at restore cycle 3
    run_a(2, 3, 1'b0);

    // Reset in the middle of a restore
    load_a(1'b0);
    a_valid = 1'b1;
    a_req   = 1'b1;
    tick();
    a_req = 1'b0;
    for (int i = 0; i < 4; i++) tick();
    chk("pre_reset_writing", a_wr_en, 2'b11);
    #2;
    rst_n = 1'b0;
    a_exp_addr.delete();
    a_exp_data.delete();
    #1;
    chk("async_reset_wr_en", a_wr_en, 0);
    chk("async_reset_busy", a_busy, 0);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_reset_idle", {a_busy, a_done, a_wr_en}, 0);
    run_a(0, -1, 1'b0);

    // Randomized restores
    for (int it = 0; it < 4; it++)
      run_a(int'($urandom_range(0, 5)), int'($urandom_range(0, 15)), 1'b0);

    // Single-port configuration including r0
    run_b();
    run_b();

    tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
